// File: rtl/dpram_fifo_pkg.sv
// rtl/dpram_fifo_pkg.sv - shared constants and depth helper for dpram_fifo
package dpram_fifo_pkg;

  localparam int BUF_SLOTS      = 2;
  localparam int RAM_RD_LATENCY = 1;

  function automatic int depth_of(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/dpram_fifo_dpram.sv
// rtl/dpram_fifo_dpram.sv - simple dual-port RAM, port A write, port B registered read
module DPRAM #(
  parameter int numwords_a = 32,
  parameter int numwords_b = 32,
  parameter int widthad_a  = 5,
  parameter int widthad_b  = 5,
  parameter int width_a    = 32,
  parameter int width_b    = 32
) (
  input  logic                 clock,
  input  logic                 wren_a,
  input  logic [widthad_a-1:0] address_a,
  input  logic [width_a-1:0]   data_a,
  input  logic [widthad_b-1:0] address_b,
  output logic [width_b-1:0]   q_b
);

  localparam int WORDS = (numwords_a > numwords_b) ? numwords_a : numwords_b;

  logic [width_a-1:0] mem [WORDS];

  always_ff @(posedge clock) begin
    if (wren_a) begin
      mem[address_a] <= data_a;
    end
    q_b <= width_b'(mem[address_b]);
  end

endmodule

// File: rtl/dpram_fifo.sv
// rtl/dpram_fifo.sv - first-word-fall-through FIFO over DPRAM with 2-entry output buffer
// Optional feature: DPRAM_FIFO_AFULL_EN adds the registered almost_full_out flag.
module dpram_fifo
  import dpram_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2  = 5,
  parameter int WIDTH       = 32,
  parameter int AFULL_LEVEL = depth_of(DEPTH_LOG2) - 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_in,
  input  logic [WIDTH-1:0]      data_in,
  output logic                  full_out,
  input  logic                  read_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  valid_out,
  output logic [DEPTH_LOG2:0]   count_out
`ifdef DPRAM_FIFO_AFULL_EN
 ,output logic                  almost_full_out
`endif
);

  localparam int DEPTH = depth_of(DEPTH_LOG2);
  localparam int CW    = DEPTH_LOG2 + 1;

  if (RAM_RD_LATENCY != 1) begin : g_latency_check
    $error("dpram_fifo assumes a single-cycle DPRAM read");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         ram_cnt, ram_cnt_nxt, count_nxt;
  logic                  rd_pend;
  logic [1:0]            buf_cnt, buf_cnt_nxt, buf_left;
  logic [2:0]            occupied;
  logic [WIDTH-1:0]      skid, skid_nxt, head_nxt, q_b;
  logic                  push, pop, issue;

  assign push = write_in && !full_out;
  assign pop  = read_in && valid_out;

  // A read is issued only if its data will find a free slot when it lands.
  always_comb begin
    occupied = {1'b0, buf_cnt} + {2'b0, rd_pend};
    issue    = (ram_cnt != '0) && (occupied < 3'(BUF_SLOTS) + {2'b0, pop});
  end

  always_comb begin
    buf_left    = buf_cnt - {1'b0, pop};
    head_nxt    = data_out;
    skid_nxt    = skid;
    buf_cnt_nxt = buf_left + {1'b0, rd_pend};
    if (pop) begin
      head_nxt = skid;
    end
    if (rd_pend) begin
      case (buf_left)
        2'd0:    head_nxt = q_b;
        2'd1:    skid_nxt = q_b;
        default: skid_nxt = skid;
      endcase
    end
    ram_cnt_nxt = ram_cnt + CW'(push) - CW'(issue);
    count_nxt   = count_out + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      rd_pend   <= 1'b0;
      buf_cnt   <= '0;
      skid      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      count_out <= '0;
      full_out  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      ram_cnt   <= ram_cnt_nxt;
      rd_pend   <= issue;
      buf_cnt   <= buf_cnt_nxt;
      skid      <= skid_nxt;
      data_out  <= head_nxt;
      valid_out <= (buf_cnt_nxt != '0);
      count_out <= count_nxt;
      full_out  <= (count_nxt == CW'(DEPTH));
    end
  end

`ifdef DPRAM_FIFO_AFULL_EN
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_afull_check
    $error("AFULL_LEVEL must lie in 1..DEPTH");
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      almost_full_out <= 1'b0;
    end else begin
      almost_full_out <= (count_nxt >= CW'(AFULL_LEVEL));
    end
  end
`endif

  DPRAM #(
    .numwords_a (DEPTH),
    .numwords_b (DEPTH),
    .widthad_a  (DEPTH_LOG2),
    .widthad_b  (DEPTH_LOG2),
    .width_a    (WIDTH),
    .width_b    (WIDTH)
  ) u_ram (
    .clock     (clock),
    .wren_a    (push),
    .address_a (wr_ptr),
    .data_a    (data_in),
    .address_b (rd_ptr),
    .q_b       (q_b)
  );

endmodule

// File: tb/tb_dpram_fifo.sv
// tb/tb_dpram_fifo.sv - randomized scoreboard bench for dpram_fifo
module tb_dpram_fifo;

  localparam int DEPTH_LOG2 = 5;
  localparam int WIDTH      = 32;
  localparam int DEPTH      = 32;
  localparam int AFULL      = 28;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                write_in = 1'b0;
  logic                read_in = 1'b0;
  logic [WIDTH-1:0]    data_in = '0;
  logic                full_out, valid_out;
  logic [WIDTH-1:0]    data_out;
  logic [DEPTH_LOG2:0] count_out;
`ifdef DPRAM_FIFO_AFULL_EN
  logic                almost_full_out;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          run_mon = 1'b0;
  bit          no_gap = 1'b0;
  logic [31:0] exp_q[$];
  int          ts_q[$];

  always #5 clock = ~clock;

  dpram_fifo #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .WIDTH       (WIDTH),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .write_in  (write_in),
    .data_in   (data_in),
    .full_out  (full_out),
    .read_in   (read_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .count_out (count_out)
`ifdef DPRAM_FIFO_AFULL_EN
   ,.almost_full_out (almost_full_out)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: an ordered queue of accepted words with their push cycle.
  always @(negedge clock) begin
    if (run_mon) begin
      bit push_ok;
      check("count", 32'(count_out), 32'(exp_q.size()));
      check("full", 32'(full_out), 32'(exp_q.size() == DEPTH));
`ifdef DPRAM_FIFO_AFULL_EN
      check("afull", 32'(almost_full_out), 32'(exp_q.size() >= AFULL));
`endif
      if (valid_out) begin
        if (exp_q.size() == 0) check("valid_when_empty", 32'(valid_out), 32'd0);
        else                   check("head_data", data_out, exp_q[0]);
      end
      if (exp_q.size() > 0 && cyc - ts_q[0] >= 3) check("head_latency", 32'(valid_out), 32'd1);
      if (no_gap) check("no_bubble", 32'(valid_out), 32'd1);
      if (reset) begin
        exp_q.delete();
        ts_q.delete();
      end else begin
        push_ok = write_in && (exp_q.size() < DEPTH);
        if (read_in && valid_out && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(ts_q.pop_front());
        end
        if (push_ok) begin
          exp_q.push_back(data_in);
          ts_q.push_back(cyc);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [31:0] d, input logic r);
    write_in = w;
    data_in  = d;
    read_in  = r;
    @(posedge clock);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(0, 0, 0);
    drive(0, 0, 0);
    run_mon = 1'b1;
    @(negedge clock);
    check("rst_count", 32'(count_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_full", 32'(full_out), 0);
    check("rst_data", data_out, 0);
    next_cycle();
    reset = 1'b0;

    // Single word latency on an empty FIFO.
    drive(1, 32'hA5, 0);
    write_in = 1'b0;
    @(negedge clock);
    check("a5_count_c1", 32'(count_out), 1);
    check("a5_valid_c1", 32'(valid_out), 0);
    next_cycle();
    @(negedge clock);
    check("a5_valid_c2", 32'(valid_out), 0);
    next_cycle();
    @(negedge clock);
    check("a5_valid_c3", 32'(valid_out), 1);
    check("a5_data_c3", data_out, 32'hA5);
    next_cycle();
    drive(0, 0, 1);
    drive(0, 0, 0);

    // Fill to capacity, overflow attempt, then drain.
    for (int i = 0; i < DEPTH; i++) drive(1, 32'(i), 0);
    write_in = 1'b0;
    @(negedge clock);
    check("fill_full", 32'(full_out), 1);
    check("fill_count", 32'(count_out), DEPTH);
    next_cycle();
    drive(1, 32'hFF, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    for (int i = 0; i < DEPTH + 8; i++) drive(0, 0, 1);
    read_in = 1'b0;
    @(negedge clock);
    check("drain_valid", 32'(valid_out), 0);
    check("drain_count", 32'(count_out), 0);
    next_cycle();

    // Streaming push and pop every cycle.
    for (int i = 0; i < 3; i++) drive(1, 32'h1000 + 32'(i), 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    no_gap = 1'b1;
    for (int i = 0; i < 200; i++) drive(1, 32'h1003 + 32'(i), 1);
    @(negedge clock);
    check("stream_count", 32'(count_out), 3);
    next_cycle();
    no_gap = 1'b0;
    for (int i = 0; i < 8; i++) drive(0, 0, 1);

    // Head held while consumer stalls.
    drive(1, 32'h11, 0);
    for (int i = 0; i < 10; i++) drive(1, $urandom, 0);
    write_in = 1'b0;
    @(negedge clock);
    check("hold_valid", 32'(valid_out), 1);
    check("hold_data", data_out, 32'h11);
    next_cycle();

    // Random traffic: a filling phase followed by a draining phase.
    for (int i = 0; i < 250; i++) drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1);
    for (int i = 0; i < 250; i++) drive($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < DEPTH + 8; i++) drive(0, 0, 1);

    // Reset while ten words are stored.
    for (int i = 0; i < 10; i++) drive(1, 32'h100 + 32'(i), 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0);
    reset = 1'b1;
    drive(0, 0, 0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_count", 32'(count_out), 0);
    check("midrst_valid", 32'(valid_out), 0);
    next_cycle();
    drive(1, 32'h77, 0);
    write_in = 1'b0;
    @(negedge clock);
    check("post_rst_count", 32'(count_out), 1);
    next_cycle();
    @(negedge clock);
    check("post_rst_valid_c2", 32'(valid_out), 0);
    next_cycle();
    @(negedge clock);
    check("post_rst_valid_c3", 32'(valid_out), 1);
    check("post_rst_data_c3", data_out, 32'h77);
    next_cycle();
    drive(0, 0, 1);
    drive(0, 0, 0);
    @(negedge clock);
    check("post_rst_alone", 32'(valid_out), 0);
    next_cycle();

`ifdef DPRAM_FIFO_AFULL_EN
    for (int i = 0; i < AFULL - 1; i++) drive(1, 32'h200 + 32'(i), 0);
    write_in = 1'b0;
    @(negedge clock);
    check("afull_at_27", 32'(almost_full_out), 0);
    next_cycle();
    drive(1, 32'h2FF, 0);
    write_in = 1'b0;
    @(negedge clock);
    check("afull_at_28", 32'(almost_full_out), 1);
    next_cycle();
    drive(0, 0, 1);
    read_in = 1'b0;
    @(negedge clock);
    check("afull_back_27", 32'(almost_full_out), 0);
    next_cycle();
    for (int i = 0; i < DEPTH + 8; i++) drive(0, 0, 1);
`endif

    drive(0, 0, 0);
    drive(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
